// File: rtl/hmac_seq_pkg.sv
// Shared types and widths for the word-serial HMAC-SHA256 (212-byte) sequencer.
// The operand is {key, message}: 640 key bits followed by 1056 message bits.
package hmac_seq_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        UNLOAD = 2'd3
    } hmac_seq_state_t;

    localparam int HMAC_IN_W  = 1696;
    localparam int HMAC_KEY_W = 640;
    localparam int HMAC_OUT_W = 256;

endpackage

// File: rtl/hmac_sha256_212_seq.sv
// Word-serial front-end/back-end around the 212-byte HMAC-SHA256 core: packs 53 words
// into the operand, pulses the core's enable, waits for its hash and streams out 8 words.
module hmac_sha256_212_seq
    import hmac_seq_pkg::*;
#(
    parameter int WORD_W      = 32,
    parameter int N_IN        = 53,
    parameter int N_OUT       = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WORD_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [HMAC_IN_W-1:0]  hmac_data,
    output logic                  hmac_enable,
    input  logic [HMAC_OUT_W-1:0] hmac_hash,
    input  logic                  hmac_done,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int IN_CNT_W  = $clog2(N_IN);
    localparam int OUT_CNT_W = $clog2(N_OUT);
    localparam int WAIT_W    = $clog2(TIMEOUT_CYC);

    localparam logic [IN_CNT_W-1:0]  IN_LAST   = IN_CNT_W'(N_IN - 1);
    localparam logic [OUT_CNT_W-1:0] OUT_LAST  = OUT_CNT_W'(N_OUT - 1);
    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    hmac_seq_state_t state, next_state;

    logic [IN_CNT_W-1:0]            in_cnt;
    logic [OUT_CNT_W-1:0]           out_cnt;
    logic [WAIT_W-1:0]              wait_cnt;
    logic [N_OUT-1:0][WORD_W-1:0]   result;

    logic in_accept;
    logic out_hs;

    assign in_accept = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // A done that coincides with the last WAIT cycle takes priority over the timeout.
    always_comb begin
        next_state = state;
        unique case (state)
            LOAD: begin
                if (in_accept && (in_cnt == IN_LAST)) begin
                    next_state = START;
                end
            end
            START: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (hmac_done) begin
                    next_state = UNLOAD;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = LOAD;
                end
            end
            UNLOAD: begin
                if (out_hs && (out_cnt == OUT_LAST)) begin
                    next_state = LOAD;
                end
            end
            default: begin
                next_state = LOAD;
            end
        endcase
    end

    always_comb begin
        in_ready    = 1'b0;
        hmac_enable = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        unique case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            START: begin
                hmac_enable = 1'b1;
            end
            WAIT: begin
                busy = 1'b1;
            end
            UNLOAD: begin
                out_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // result[N_OUT-1] holds the most significant hash word, so it leaves first.
    assign out_data = result[OUT_LAST - out_cnt];
    assign out_last = out_valid && (out_cnt == OUT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hmac_data   <= '0;
            result      <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (in_accept) begin
                        hmac_data   <= {hmac_data[HMAC_IN_W-WORD_W-1:0], in_data};
                        in_cnt      <= (in_cnt == IN_LAST) ? '0 : in_cnt + 1'b1;
                        timeout_err <= 1'b0;
                    end
                end
                START: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (hmac_done) begin
                        result  <= hmac_hash;
                        out_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_LAST) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                UNLOAD: begin
                    if (out_hs) begin
                        out_cnt <= out_cnt + 1'b1;
                    end
                end
                default: begin
                    in_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/hmac_sha256_212_seq.md
# hmac_sha256_212_seq

Word-serial front-end and back-end for the 212-byte HMAC-SHA256 block in the scrypt datapath. It assembles 53 incoming 32-bit words into the 1696-bit `{key, message}` HMAC operand and fires a single-cycle start pulse. It then waits for the hash and streams the 256-bit result out as 8 words over a valid/ready handshake. It is the initiator/consumer side of the HMAC `data/enable → hash/hash_done` interface.

## Interface
- `WORD_W`, 32, word width of the in/out streams
- `N_IN`, 53, input words per operation (N_IN*WORD_W = 1696)
- `N_OUT`, 8, output words per hash (N_OUT*WORD_W = 256)
- `TIMEOUT_CYC`, 4096, maximum cycles spent in WAIT before abort

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_data`  in  32  input word, first word = MS word of the operand
- `in_valid`  in  1  input word present
- `in_ready`  out  1  block accepts an input word
- `out_data`  out  32  hash word, MS word first
- `out_valid`  out  1  hash word present
- `out_ready`  in  1  downstream accepts the word
- `out_last`  out  1  marks the 8th hash word
- `hmac_data`  out  1696  operand to HMAC: [1695:1056] key, [1055:0] message
- `hmac_enable`  out  1  one-cycle start pulse to HMAC
- `hmac_hash`  in  256  HMAC result
- `hmac_done`  in  1  HMAC result valid
- `busy`  out  1  high in START, WAIT, and UNLOAD
- `timeout_err`  out  1  sticky, set on WAIT timeout

## Operation
- States: LOAD → START → WAIT → UNLOAD → LOAD.
- LOAD: `in_ready`=1. Each `in_valid && in_ready` shifts the operand register left by 32, inserts `in_data` at [31:0], and increments `in_cnt` (0..52). The 53rd accept places word 0 at [1695:1664], clears `in_cnt`, and moves to START.
- START: `hmac_enable`=1 for exactly one cycle. Clear `wait_cnt`. Go to WAIT.
- WAIT: `hmac_done`=1 latches `hmac_hash` into the result register, clears `out_cnt`, and moves to UNLOAD. Otherwise `wait_cnt` increments. When `wait_cnt` reaches TIMEOUT_CYC-1 without done, set `timeout_err`, discard the operation, and return to LOAD.
- UNLOAD: `out_valid`=1 and `out_data` = result[255-32*out_cnt -: 32]. `out_last` = (`out_cnt`==7). Each handshake increments `out_cnt`. The handshake on the last word returns to LOAD.
- `hmac_done` outside WAIT is ignored. `in_valid` outside LOAD is not accepted; `in_ready` is 0.
- `timeout_err` clears on the first input accept of the next operation.
- `hmac_data` is a direct register output. It is stable from START until the next LOAD accept.

## Timing
- Reset: state=LOAD; all counters 0; operand and result registers 0. `hmac_enable`, `out_valid`, `out_last`, `busy`, and `timeout_err` are 0. `in_ready` is 1 from the first cycle after reset deassertion.
- Reset mid-operation aborts immediately. No partial output appears after reset.
- Input: minimum 53 cycles with `in_valid` held high. Stalls of any length are allowed between words.
- The 53rd accept is at edge N. `hmac_enable` is high during cycle N+1. WAIT begins at N+2.
- `hmac_done` sampled at edge M gives `out_valid`=1 from cycle M+1.
- Output: 8 cycles minimum with `out_ready` tied high. `out_data` and `out_last` hold while `out_valid && !out_ready`.
- Back-to-back operation: `in_ready` rises the cycle after the last output handshake.
- `hmac_done` in the same cycle the timeout fires: done wins and no error is set.

## Structure
- Package `hmac_seq_pkg` holds:
  - the state enum `hmac_seq_state_t` (LOAD, START, WAIT, UNLOAD)
  - localparams `HMAC_IN_W`=1696, `HMAC_KEY_W`=640, `HMAC_OUT_W`=256
- One flat module; no sub-module is needed.
- The HMAC core is instantiated by the parent, not inside this block.

## Test plan
- **Reset:** assert `rst` mid-LOAD after 20 words → `in_ready`=1, `in_cnt`=0, all outputs 0. A fresh 53 words then produce exactly one `hmac_enable`.
- **Packing:** send words 0x00000000..0x00000034 → `hmac_data`[1695:1664]=0x00000000 and [31:0]=0x00000034. `hmac_enable` is high for exactly 1 cycle, 1 cycle after the last accept.
- **Unload order:** `hmac_hash`=0x0001..0x0008 packed MS-first, done after 100 cycles → `out_data` sequence 0x1..0x8. `out_last` is high only on 0x8.
- **Backpressure:** toggle `out_ready` at random during UNLOAD → no word dropped or duplicated, and `out_data` is stable while stalled. Toggle `in_valid` at random during LOAD → the packed operand is unchanged versus the no-stall run.
- **Timeout:** `hmac_done` never asserted → `timeout_err`=1 after 4096 WAIT cycles, state returns to LOAD, and no `out_valid`. The next input accept clears `timeout_err`.
- **Spurious done:** `hmac_done` pulsed during LOAD and UNLOAD → ignored. Output matches the hash latched in WAIT.
